// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
//
// Top-level control unit for the perceptron training datapath. A run is a
// series of epochs. Each epoch is a TRAIN pass over all NSAMP samples
// (weight-update enable), an EVAL pass over all samples (error accumulation),
// and a one-cycle CHECK. CHECK decides whether to stop on convergence, stop
// on the epoch limit, or start the next epoch.
//
// Optional feature: define TRAIN_SEQ_ABORT_EN to add the 'abort' input. When
// it is high in TRAIN, EVAL or CHECK, the run ends in DONE on the next cycle
// with converged=0. epoch and err_acc keep their current values.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start        pulse; begins a run from IDLE or DONE (ignored while busy)
//   thresh       convergence threshold, latched at start
//   sample_done  datapath finished the current sample
//   err_in       error magnitude of the current sample (valid with sample_done)
//   abort        (TRAIN_SEQ_ABORT_EN only) ends the run early
//   sample_req   datapath should process the sample at addr
//   addr         current sample index
//   en_cc        weight-update enable (TRAIN pass)
//   en_err       error-accumulate enable (EVAL pass)
//   epoch        completed epoch count
//   err_acc      accumulated error of the current/last epoch (saturating)
//   busy         run in progress
//   done         run finished
//   converged    run ended with err_acc <= threshold
// -----------------------------------------------------------------------------
module train_sequencer #(
    parameter int NSAMP     = 150,
    parameter int CNT_W     = 8,
    parameter int MAX_EPOCH = 16,
    parameter int EP_W      = 5,
    parameter int ERR_W     = 16,
    parameter int ACC_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] thresh,
    input  logic             sample_done,
    input  logic [ERR_W-1:0] err_in,
`ifdef TRAIN_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             sample_req,
    output logic [CNT_W-1:0] addr,
    output logic             en_cc,
    output logic             en_err,
    output logic [EP_W-1:0]  epoch,
    output logic [ACC_W-1:0] err_acc,
    output logic             busy,
    output logic             done,
    output logic             converged
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRAIN = 3'd1,
        S_EVAL  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The wrap point comes from NSAMP, not from natural counter overflow.
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NSAMP - 1);
    localparam logic [EP_W-1:0]  MAX_EP    = EP_W'(MAX_EPOCH);

    state_t           state_r;
    logic [ACC_W-1:0] thresh_r;

    logic             abort_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] sat_acc_s;
    logic [EP_W-1:0]  epoch_inc_s;
    logic             last_addr_s;
    logic [CNT_W-1:0] next_addr_s;

`ifdef TRAIN_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Saturating error add, epoch increment and sample-address advance.
    always_comb begin
        sum_s       = {1'b0, err_acc} + {{(ACC_W + 1 - ERR_W){1'b0}}, err_in};
        sat_acc_s   = sum_s[ACC_W-1:0];
        epoch_inc_s = epoch + EP_W'(1);
        last_addr_s = (addr == LAST_ADDR);
        next_addr_s = addr + CNT_W'(1);
        if (sum_s[ACC_W]) begin
            sat_acc_s = {ACC_W{1'b1}};
        end else begin
            sat_acc_s = sum_s[ACC_W-1:0];
        end
        if (last_addr_s) begin
            next_addr_s = {CNT_W{1'b0}};
        end else begin
            next_addr_s = addr + CNT_W'(1);
        end
    end

    // Sequencer FSM. The Moore outputs are registered and updated together
    // with the state transition, so they always match the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            thresh_r   <= {ACC_W{1'b0}};
            sample_req <= 1'b0;
            addr       <= {CNT_W{1'b0}};
            en_cc      <= 1'b0;
            en_err     <= 1'b0;
            epoch      <= {EP_W{1'b0}};
            err_acc    <= {ACC_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    // Without start, DONE simply holds its results.
                    if (start) begin
                        state_r    <= S_TRAIN;
                        thresh_r   <= thresh;
                        addr       <= {CNT_W{1'b0}};
                        epoch      <= {EP_W{1'b0}};
                        err_acc    <= {ACC_W{1'b0}};
                        converged  <= 1'b0;
                        done       <= 1'b0;
                        sample_req <= 1'b1;
                        en_cc      <= 1'b1;
                        en_err     <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_TRAIN: begin
                    if (abort_s) begin
                        state_r    <= S_DONE;
                        converged  <= 1'b0;
                        done       <= 1'b1;
                        sample_req <= 1'b0;
                        en_cc      <= 1'b0;
                        en_err     <= 1'b0;
                        busy       <= 1'b0;
                    end else if (sample_done) begin
                        addr <= next_addr_s;
                        if (last_addr_s) begin
                            state_r <= S_EVAL;
                            en_cc   <= 1'b0;
                            en_err  <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (abort_s) begin
                        state_r    <= S_DONE;
                        converged  <= 1'b0;
                        done       <= 1'b1;
                        sample_req <= 1'b0;
                        en_cc      <= 1'b0;
                        en_err     <= 1'b0;
                        busy       <= 1'b0;
                    end else if (sample_done) begin
                        err_acc <= sat_acc_s;
                        addr    <= next_addr_s;
                        if (last_addr_s) begin
                            state_r    <= S_CHECK;
                            sample_req <= 1'b0;
                            en_err     <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (abort_s) begin
                        state_r   <= S_DONE;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        epoch <= epoch_inc_s;
                        // err_acc already holds the final EVAL add here.
                        if (err_acc <= thresh_r) begin
                            state_r   <= S_DONE;
                            converged <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else if (epoch_inc_s == MAX_EP) begin
                            state_r   <= S_DONE;
                            converged <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state_r    <= S_TRAIN;
                            err_acc    <= {ACC_W{1'b0}};
                            sample_req <= 1'b1;
                            en_cc      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    sample_req <= 1'b0;
                    en_cc      <= 1'b0;
                    en_err     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    converged  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_train_sequencer
//
// Self-checking bench for train_sequencer with NSAMP=4, MAX_EPOCH=3 and
// ERR_W=ACC_W=4, so that convergence, epoch limit and saturation can all be
// exercised on one instance. Every sample the bench expects the DUT to serve
// is pushed to a scoreboard queue as {en_cc, en_err, addr}. The queue is
// popped whenever the DUT is seen requesting a sample while sample_done is
// high.
// -----------------------------------------------------------------------------
module tb_train_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] thresh;
    logic       sample_done;
    logic [3:0] err_in;
`ifdef TRAIN_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       sample_req;
    logic [7:0] addr;
    logic       en_cc;
    logic       en_err;
    logic [4:0] epoch;
    logic [3:0] err_acc;
    logic       busy;
    logic       done;
    logic       converged;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    train_sequencer #(
        .NSAMP    (4),
        .CNT_W    (8),
        .MAX_EPOCH(3),
        .EP_W     (5),
        .ERR_W    (4),
        .ACC_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .thresh     (thresh),
        .sample_done(sample_done),
        .err_in     (err_in),
`ifdef TRAIN_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .sample_req (sample_req),
        .addr       (addr),
        .en_cc      (en_cc),
        .en_err     (en_err),
        .epoch      (epoch),
        .err_acc    (err_acc),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: score any served sample at the falling edge, then
    // return 1 time unit after the next rising edge.
    task automatic tick();
        logic [9:0] exp_v;
        @(negedge clk);
        if (sample_req && sample_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got cc=%0b err=%0b addr=%0d required no sample",
                         en_cc, en_err, addr);
            end else begin
                exp_v = exp_q.pop_front();
                if ({en_cc, en_err, addr} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_sample got cc=%0b err=%0b addr=%0d required cc=%0b err=%0b addr=%0d",
                             en_cc, en_err, addr, exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input logic cc, input int n);
        logic [7:0] a8;
        for (int a = 0; a < n; a++) begin
            a8 = 8'(a);
            exp_q.push_back({cc, ~cc, a8});
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({sample_req, addr, en_cc, en_err, epoch, err_acc, busy, done, converged} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs got req=%0b addr=%0d ep=%0d acc=%0d busy=%0b done=%0b required all 0",
                     sample_req, addr, epoch, err_acc, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_done = 1'b1;
        err_in = 4'd5;
        repeat (3) tick();
        sample_done = 1'b0;
        checks++;
        if ({addr, busy, err_acc, sample_req} !== 14'd0) begin
            errors++;
            $display("FAIL idle_ignore got addr=%0d busy=%0b acc=%0d req=%0b required 0 0 0 0",
                     addr, busy, err_acc, sample_req);
        end
    endtask

    task automatic test_converge();
        int n_check = 0;
        int n_cyc = 0;
        thresh = 4'd10;
        err_in = 4'd2;
        push_pass(1'b1, 4);
        push_pass(1'b0, 4);
        do_start();
        checks++;
        if ({sample_req, en_cc, en_err, busy, addr} !== {4'b1101, 8'd0}) begin
            errors++;
            $display("FAIL start_latency got req=%0b cc=%0b err=%0b busy=%0b addr=%0d required 1 1 0 1 0",
                     sample_req, en_cc, en_err, busy, addr);
        end
        sample_done = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (busy && !sample_req) n_check++;
            tick();
            n_cyc++;
        end
        sample_done = 1'b0;
        checks++;
        if ({done, converged, busy, epoch, err_acc} !== {3'b110, 5'd1, 4'd8}) begin
            errors++;
            $display("FAIL converge_result got done=%0b conv=%0b busy=%0b ep=%0d acc=%0d required 1 1 0 1 8",
                     done, converged, busy, epoch, err_acc);
        end
        checks++;
        if (n_check != 1 || n_cyc != 9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL converge_timing got check_cycles=%0d cycles=%0d left=%0d required 1 9 0",
                     n_check, n_cyc, exp_q.size());
        end
        repeat (2) tick();
        checks++;
        if ({done, converged, epoch, err_acc} !== {2'b11, 5'd1, 4'd8}) begin
            errors++;
            $display("FAIL done_hold got done=%0b conv=%0b ep=%0d acc=%0d required 1 1 1 8",
                     done, converged, epoch, err_acc);
        end
    endtask

    task automatic test_epoch_limit();
        int n_check = 0;
        int n_cyc = 0;
        thresh = 4'd0;
        err_in = 4'd1;
        for (int e = 0; e < 3; e++) begin
            push_pass(1'b1, 4);
            push_pass(1'b0, 4);
        end
        do_start();
        checks++;
        if ({epoch, err_acc, done, converged} !== 11'd0) begin
            errors++;
            $display("FAIL restart_clear got ep=%0d acc=%0d done=%0b conv=%0b required 0 0 0 0",
                     epoch, err_acc, done, converged);
        end
        sample_done = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (busy && !sample_req) begin
                n_check++;
                checks++;
                if (err_acc !== 4'd4) begin
                    errors++;
                    $display("FAIL epoch_acc got acc=%0d required 4", err_acc);
                end
            end
            tick();
            n_cyc++;
        end
        sample_done = 1'b0;
        checks++;
        if ({done, converged, epoch, err_acc} !== {2'b10, 5'd3, 4'd4} ||
            n_check != 3 || n_cyc != 27 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL epoch_limit got done=%0b conv=%0b ep=%0d acc=%0d checks=%0d cycles=%0d required 1 0 3 4 3 27",
                     done, converged, epoch, err_acc, n_check, n_cyc);
        end
    endtask

    task automatic test_saturation();
        thresh = 4'd15;
        err_in = 4'd15;
        push_pass(1'b1, 4);
        push_pass(1'b0, 4);
        do_start();
        sample_done = 1'b1;
        repeat (6) tick();
        checks++;
        if ({en_err, addr, err_acc} !== {1'b1, 8'd2, 4'd15}) begin
            errors++;
            $display("FAIL sat_midpass got err=%0b addr=%0d acc=%0d required 1 2 15",
                     en_err, addr, err_acc);
        end
        for (int c = 0; c < 20 && !done; c++) tick();
        sample_done = 1'b0;
        checks++;
        if ({done, converged, epoch, err_acc} !== {2'b11, 5'd1, 4'd15}) begin
            errors++;
            $display("FAIL sat_result got done=%0b conv=%0b ep=%0d acc=%0d required 1 1 1 15",
                     done, converged, epoch, err_acc);
        end
    endtask

    task automatic test_gaps();
        thresh = 4'd15;
        err_in = 4'd3;
        push_pass(1'b1, 4);
        push_pass(1'b0, 4);
        do_start();
        for (int c = 0; c < 100 && !done; c++) begin
            sample_done = (c % 3 == 2);
            start = (c == 4);
            tick();
            if (c == 4) begin
                checks++;
                if ({addr, en_cc, busy} !== {8'd1, 2'b11}) begin
                    errors++;
                    $display("FAIL start_in_train got addr=%0d cc=%0b busy=%0b required 1 1 1",
                             addr, en_cc, busy);
                end
            end
        end
        start = 1'b0;
        sample_done = 1'b0;
        checks++;
        if ({done, converged, epoch, err_acc} !== {2'b11, 5'd1, 4'd12} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_result got done=%0b conv=%0b ep=%0d acc=%0d left=%0d required 1 1 1 12 0",
                     done, converged, epoch, err_acc, exp_q.size());
        end
    endtask

    task automatic test_reset_midrun();
        thresh = 4'd0;
        err_in = 4'd1;
        push_pass(1'b1, 4);
        push_pass(1'b0, 4);
        do_start();
        sample_done = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sample_req, addr, en_cc, en_err, epoch, err_acc, busy, done, converged} !== 24'd0) begin
            errors++;
            $display("FAIL async_reset got req=%0b addr=%0d err=%0b ep=%0d acc=%0d busy=%0b required all 0",
                     sample_req, addr, en_err, epoch, err_acc, busy);
        end
        sample_done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if ({epoch, busy, addr, done} !== 15'd0) begin
            errors++;
            $display("FAIL post_reset got ep=%0d busy=%0b addr=%0d done=%0b required 0 0 0 0",
                     epoch, busy, addr, done);
        end
    endtask

`ifdef TRAIN_SEQ_ABORT_EN
    task automatic test_abort();
        thresh = 4'd0;
        err_in = 4'd3;
        push_pass(1'b1, 4);
        push_pass(1'b0, 3);
        do_start();
        sample_done = 1'b1;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sample_done = 1'b0;
        checks++;
        if ({done, converged, sample_req, busy, epoch, err_acc} !== {4'b1000, 5'd0, 4'd6} ||
            exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_eval got done=%0b conv=%0b req=%0b busy=%0b ep=%0d acc=%0d required 1 0 0 0 0 6",
                     done, converged, sample_req, busy, epoch, err_acc);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        thresh = 4'd0;
        sample_done = 1'b0;
        err_in = 4'd0;
`ifdef TRAIN_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_converge();
        test_epoch_limit();
        test_saturation();
        test_gaps();
        test_reset_midrun();
`ifdef TRAIN_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
